md_sched: RTL and testbench

MD_SCHED -- requirements
Module: md_sched

---
 rtl/md_sched.sv | 220 ++++++++++++++++++++++
 tb/tb_md_sched.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// ---------------------------------------------------------------------------
// md_sched : HI/LO multiply/divide unit scheduler for a 5-stage MIPS-like core.
//
// Accepts an E-stage multiply/divide-unit instruction when idle. MULT/MULTU
// and DIV/DIVU latch their operands and run for MULT_LAT / DIV_LAT busy
// cycles. The result is written to HI/LO at the edge that ends the last busy
// cycle. MTHI/MTLO write HI/LO in a single cycle without becoming busy.
// A combinational stall request holds back any D-stage instruction that
// touches HI/LO while the unit is busy or is about to become busy.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     E-stage mul/div-unit instruction valid this cycle
//   op        0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   rs_val    forwarded rs operand
//   rt_val    forwarded rt operand
//   d_md_use  D-stage instruction uses the mul/div unit or HI/LO
//   busy      multi-cycle operation in progress
//   stall_md  stall request to the hazard logic (combinational)
//   hi, lo    architectural HI and LO registers
// ---------------------------------------------------------------------------
module md_sched #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  // The counter is loaded with LAT-1 so that the counter-zero cycle is the
  // last busy cycle; LAT busy cycles in total.
  localparam logic [3:0] MUL_CNT = 4'(MULT_LAT - 1);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

  // 64-bit product returned as {hi, lo}; signed mode sign-extends both
  // operands so the low 64 bits of the wide product are the signed result.
  function automatic logic [63:0] mul_hilo(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic        sgn);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = {(sgn ? {32{a[31]}} : 32'd0), a};
    eb = {(sgn ? {32{b[31]}} : 32'd0), b};
    return ea * eb;
  endfunction

  // Division returned as {remainder, quotient}. Signed mode divides the
  // magnitudes and fixes the signs afterwards: the quotient is negative when
  // the operand signs differ (truncation toward zero) and the remainder takes
  // the sign of the dividend. Working on magnitudes also gives the MIPS answer
  // for 0x80000000 / -1 (quotient 0x80000000, remainder 0) without overflow.
  // Never called for a zero divisor in a way that reaches HI/LO.
  function automatic logic [63:0] div_hilo(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic        sgn);
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_out;
    logic [31:0] r_out;
    neg_a = sgn & a[31];
    neg_b = sgn & b[31];
    mag_a = neg_a ? (~a + 32'd1) : a;
    mag_b = neg_b ? (~b + 32'd1) : b;
    q_mag = mag_a / mag_b;
    r_mag = mag_a % mag_b;
    q_out = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
    r_out = neg_a ? (~r_mag + 32'd1) : r_mag;
    return {r_out, q_out};
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_s;
  logic [31:0] opa_r;
  logic [31:0] opa_s;
  logic [31:0] opb_r;
  logic [31:0] opb_s;
  logic        sgn_r;
  logic        sgn_s;
  logic [31:0] hi_r;
  logic [31:0] hi_s;
  logic [31:0] lo_r;
  logic [31:0] lo_s;
  logic        busy_r;
  logic [63:0] mul_res_s;
  logic [63:0] div_res_s;

  // Result datapaths work only from the latched operands, never from the
  // live forwarded values.
  always_comb begin
    mul_res_s = mul_hilo(opa_r, opb_r, sgn_r);
    div_res_s = div_hilo(opa_r, opb_r, sgn_r);
  end

  // Next-state, counter, operand-latch and HI/LO update logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    opa_s   = opa_r;
    opb_s   = opb_r;
    sgn_s   = sgn_r;
    hi_s    = hi_r;
    lo_s    = lo_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1: begin
              state_s = MUL;
              cnt_s   = MUL_CNT;
              opa_s   = rs_val;
              opb_s   = rt_val;
              sgn_s   = (op == 3'd0);
            end
            3'd2, 3'd3: begin
              state_s = DIV;
              cnt_s   = DIV_CNT;
              opa_s   = rs_val;
              opb_s   = rt_val;
              sgn_s   = (op == 3'd2);
            end
            3'd4: begin
              hi_s = rs_val;
            end
            3'd5: begin
              lo_s = rs_val;
            end
            default: begin
              state_s = IDLE;
            end
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      MUL: begin
        if (cnt_r != 4'd0) begin
          cnt_s = cnt_r - 4'd1;
        end else begin
          hi_s    = mul_res_s[63:32];
          lo_s    = mul_res_s[31:0];
          state_s = IDLE;
        end
      end
      DIV: begin
        if (cnt_r != 4'd0) begin
          cnt_s = cnt_r - 4'd1;
        end else begin
          // A zero divisor still spends the full busy period but leaves
          // HI/LO untouched.
          if (opb_r != 32'd0) begin
            hi_s = div_res_s[63:32];
            lo_s = div_res_s[31:0];
          end else begin
            hi_s = hi_r;
          end
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State, counter, operand, busy and HI/LO registers; reset aborts any
  // operation in flight and clears HI/LO immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      opa_r   <= 32'd0;
      opb_r   <= 32'd0;
      sgn_r   <= 1'b0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      opa_r   <= opa_s;
      opb_r   <= opb_s;
      sgn_r   <= sgn_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
      busy_r  <= (state_s != IDLE);
    end
  end

  assign busy = busy_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

  // A multi-cycle op being issued this cycle must already stall the D-stage
  // HI/LO user, otherwise it would slip past before busy rises.
  assign stall_md = d_md_use && (busy_r || (start && (op <= 3'd3)));

endmodule

// File: tb/tb_md_sched.sv
// ---------------------------------------------------------------------------
// tb_md_sched : scoreboard bench for md_sched.
// The stimulus process issues directed and random instructions and, through a
// reference model built on 64-bit integer arithmetic, pushes the expected
// HI/LO value together with the cycle it must become visible. A monitor on
// the falling clock edge pops due entries and compares busy, stall_md, hi, lo
// every cycle.
// ---------------------------------------------------------------------------
module tb_md_sched;

  localparam int MLAT = 5;
  localparam int DLAT = 10;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_md_use;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  md_sched #(.MULT_LAT(MLAT), .DIV_LAT(DLAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .d_md_use (d_md_use),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo)
  );

  typedef struct {
    int          due;
    logic [31:0] hi;
    logic [31:0] lo;
  } sb_t;

  sb_t         sb_q[$];
  int          cyc = 0;
  int          busy_start = 0;
  int          busy_end = -1;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;
  logic        exp_busy;
  logic        exp_stall;
  logic        mon_en = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s @cyc %0d: actual %h required %h", name, cyc, act, req);
  endtask

  // Reference result {hi, lo} from plain 64-bit integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint          sq;
    longint          sr;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned uq;
    longint unsigned ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd0: begin
        sq = sa * sb;
        return sq;
      end
      3'd1: begin
        uq = ua * ub;
        return uq;
      end
      3'd2: begin
        if (b == 32'd0) return {model_hi, model_lo};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {model_hi, model_lo};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return {model_hi, model_lo};
    endcase
  endfunction

  task automatic push(input int due, input logic [63:0] r);
    sb_t e;
    e.due = due;
    e.hi  = r[63:32];
    e.lo  = r[31:0];
    sb_q.push_back(e);
    model_hi = r[63:32];
    model_lo = r[31:0];
  endtask

  // Apply the spec's acceptance rules to the inputs driven in cycle cyc.
  task automatic model_step();
    if (start && cyc > busy_end) begin
      case (op)
        3'd0, 3'd1: begin
          busy_start = cyc + 1;
          busy_end   = cyc + MLAT;
          push(cyc + MLAT + 1, ref_result(op, rs_val, rt_val));
        end
        3'd2, 3'd3: begin
          busy_start = cyc + 1;
          busy_end   = cyc + DLAT;
          push(cyc + DLAT + 1, ref_result(op, rs_val, rt_val));
        end
        3'd4: push(cyc + 1, {rs_val, model_lo});
        3'd5: push(cyc + 1, {model_hi, rs_val});
        default: ;
      endcase
    end
  endtask

  task automatic drive(input logic s, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic u);
    @(posedge clk);
    #1;
    start    = s;
    op       = o;
    rs_val   = a;
    rt_val   = b;
    d_md_use = u;
    model_step();
  endtask

  task automatic idle(input int n, input logic u);
    for (int i = 0; i < n; i++) drive(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, u);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops results as they fall due and compares every cycle.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_hi = 32'd0;
      exp_lo = 32'd0;
    end else if (mon_en) begin
      if (sb_q.size() > 0) begin
        if (sb_q[0].due == cyc) begin
          exp_hi = sb_q[0].hi;
          exp_lo = sb_q[0].lo;
          void'(sb_q.pop_front());
        end
      end
      exp_busy  = (cyc >= busy_start) && (cyc <= busy_end);
      exp_stall = d_md_use && (exp_busy || (start && op <= 3'd3));
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("stall_md", {31'd0, stall_md}, {31'd0, exp_stall});
      chk("hi", hi, exp_hi);
      chk("lo", lo, exp_lo);
    end
  end

  initial begin
    rst_n    = 1'b1;
    start    = 1'b0;
    op       = 3'd7;
    rs_val   = 32'd0;
    rt_val   = 32'd0;
    d_md_use = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stall", {31'd0, stall_md}, 32'd0);
    #14 rst_n = 1'b1;
    mon_en = 1'b1;

    // Signed and unsigned multiply of the same operands, D-stage user waiting.
    drive(1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1);
    idle(6, 1'b1);
    drive(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1);
    idle(6, 1'b1);
    // Signed divide with negative dividend.
    drive(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(11, 1'b0);
    // Preload HI/LO, then unsigned divide by zero must leave them alone.
    drive(1'b1, 3'd4, 32'h0000_0011, 32'd0, 1'b0);
    drive(1'b1, 3'd5, 32'h0000_0022, 32'd0, 1'b0);
    drive(1'b1, 3'd3, 32'd7, 32'd0, 1'b0);
    idle(11, 1'b0);
    // Most-negative / -1.
    drive(1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(11, 1'b0);
    // Second start during busy is ignored.
    drive(1'b1, 3'd0, 32'd1234, 32'd5678, 1'b1);
    idle(2, 1'b1);
    drive(1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    idle(6, 1'b1);
    // MTHI in IDLE, then a no-op start.
    drive(1'b1, 3'd4, 32'hA5A5_A5A5, 32'd0, 1'b0);
    drive(1'b1, 3'd6, 32'h1234_5678, 32'd0, 1'b1);
    idle(2, 1'b0);

    // Reset pulsed between edges in DIV busy cycle 4.
    drive(1'b1, 3'd2, 32'd100, 32'd7, 1'b1);
    idle(3, 1'b1);
    @(posedge clk);
    #1;
    start    = 1'b0;
    d_md_use = 1'b1;
    model_step();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_stall", {31'd0, stall_md}, 32'd0);
    sb_q.delete();
    model_hi   = 32'd0;
    model_lo   = 32'd0;
    busy_start = 0;
    busy_end   = -1;
    #1 rst_n = 1'b1;
    // Must be accepted at the very first edge after release.
    start    = 1'b1;
    op       = 3'd5;
    rs_val   = 32'h5A5A_0F0F;
    d_md_use = 1'b0;
    model_step();
    idle(12, 1'b0);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), pick(), pick(),
            1'($urandom_range(0, 1)));
    end
    idle(20, 1'b0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
